// File: rtl/display_scan.sv
// rtl/display_scan.sv - binary-to-BCD conversion and 4-digit anode scan for a 7-segment decoder
module display_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] bin,
    input  logic        load,
    input  logic        en,
    input  logic [3:0]  dp_en,
    output logic        busy,
    output logic [3:0]  an,
    output logic [3:0]  digit,
    output logic        dp_n
);

    localparam int              CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]   REF_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] scr_q, scr_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] adj;

    logic [CW-1:0] ref_q, ref_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    digit_q, digit_d;
    logic          dp_n_q, dp_n_d;
    logic [15:0]   upper;
    logic          blank;

    // add-3 correction of every scratch nibble that is 5 or more
    always_comb begin
        adj = scr_q;
        for (int k = 0; k < 4; k++) begin
            if (scr_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // conversion FSM next state; the displayed value changes only on the final shift
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    bin_d   = (bin > 14'd9999) ? 14'd9999 : bin;
                    scr_d   = 16'd0;
                    cnt_d   = 4'd0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                scr_d = 16'({adj, bin_q[13]});
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    bcd_d   = scr_d;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // conversion state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bin_q   <= 14'd0;
            scr_q   <= 16'd0;
            cnt_q   <= 4'd0;
            bcd_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    // refresh divider and slot index, free-running regardless of en/busy
    always_comb begin
        ref_d = ref_q + CW'(1);
        idx_d = idx_q;
        if (ref_q == REF_LAST) begin
            ref_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // slot outputs; a slot is blanked when it and every digit above it are zero
    always_comb begin
        upper   = bcd_q >> {idx_q, 2'b00};
        blank   = (BLANK_LZ != 0) && (idx_q != 2'd0) && (upper == 16'd0);
        digit_d = upper[3:0];
        dp_n_d  = ~dp_en[idx_q];
        an_d    = (!en || blank) ? 4'b1111 : ~(4'b0001 << idx_q);
    end

    // scan counter and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q   <= '0;
            idx_q   <= 2'd0;
            an_q    <= 4'b1111;
            digit_q <= 4'd0;
            dp_n_q  <= 1'b1;
        end else begin
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            digit_q <= digit_d;
            dp_n_q  <= dp_n_d;
        end
    end

    assign busy  = (state_q == S_SHIFT);
    assign an    = an_q;
    assign digit = digit_q;
    assign dp_n  = dp_n_q;

endmodule

// File: doc/display_scan.md
Name: display_scan

Overview:
- Upstream driver for the per-digit 7-segment decoder on the Basys board.
- Accepts a 14-bit binary value and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits across the four common anodes.
- Each scan slot presents one BCD digit, an active-low decimal point and an active-low anode enable. The decoder turns these into segment cathodes.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot. 100 MHz gives 1 kHz per digit and a 250 Hz full-frame refresh. Legal values are 2 or more.
- BLANK_LZ, 1: 1 enables leading-zero blanking, 0 shows all four digits always.

Ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous reset, active low.
- bin  in  14  unsigned value to display. Values above 9999 saturate to 9999.
- load  in  1  one-cycle strobe that captures bin and starts conversion.
- en  in  1  display enable, active high. When low, all anodes are forced off.
- dp_en  in  4  decimal point request per position, active high. Bit 0 is the rightmost digit.
- busy  out  1  high while conversion is in progress.
- an  out  4  anode enables, active low. an[0] is the rightmost digit.
- digit  out  4  BCD digit for the current slot, range 0-9, drives the decoder n input.
- dp_n  out  1  decimal point for the current slot, active low, drives the decoder Di input.

Behaviour:
- Reset (async assert, sync-safe deassert on next edge):
  - an=4'b1111, digit=0, dp_n=1, busy=0.
  - Displayed BCD register = 0000, scan index = 0, refresh counter = 0, conversion state = IDLE.
- Conversion FSM, states IDLE and SHIFT:
  - IDLE: when load=1 at edge E0, capture min(bin, 9999) into the shift register and clear the BCD scratch to 0. Set busy=1, shift count=0, go to SHIFT.
  - SHIFT: each edge, add 3 to each scratch BCD nibble that is 5 or more, then shift left one bit with the binary MSB entering the scratch.
  - After the 14th shift (edge E14), copy the scratch into the displayed BCD register in one atomic update, set busy=0 and return to IDLE.
  - busy is high for exactly 14 cycles. The new value is visible on the display from the scan slot that follows E14.
- Load handling:
  - load while busy=1 is ignored, including at E14 itself.
  - load held high in IDLE starts a new conversion every 15 cycles.
- Scan:
  - The refresh counter counts 0 to REFRESH_DIV-1 and wraps.
  - On each wrap, the scan index advances 0→1→2→3→0.
  - The counter and index run independently of en and busy.
- Outputs (registered, updated every cycle from the current index i):
  - digit = BCD[i].
  - dp_n = ~dp_en[i].
  - an = all ones except bit i = 0.
  - Output latency is 1 cycle from an index change.
- Blanking:
  - When BLANK_LZ=1 and i>0 and BCD[3:i] are all zero, an is forced to 4'b1111 for that slot. digit still equals 0 and dp_n is unaffected.
  - Digit 0 is never blanked, so value 0 shows "0".
- en=0 forces an=4'b1111. digit and dp_n still track the scan.
- Reset mid-conversion aborts it: displayed register = 0, busy=0, and no stale update follows.
- Saturation check is bin > 14'd9999 → 9999. Valid digit range is 0-9 by construction.

Test Plan:
- Reset, REFRESH_DIV=4, en=1 → an=1110 and digit=0 on the first slot. an stays 1111 in slots 1-3 (blanked).
- load with bin=1234 → busy high exactly 14 cycles. Scan then shows digit 4,3,2,1 with an=1110,1101,1011,0111, each for 4 cycles.
- load with bin=16383 → displays 9,9,9,9. load with bin=9999 gives the same result.
- bin=7, BLANK_LZ=1 → only an[0] is active, digit=7. With BLANK_LZ=0, all anodes cycle and digits 7,0,0,0 are shown.
- During busy for 1234, pulse load with bin=5 at cycle 5 and at E14 → both are ignored and 1234 is displayed. A load after busy falls converts 5.
- dp_en=4'b0100, en toggled low → dp_n=0 only in slot 2. en=0 gives an=1111 for the whole period.
- Assert rst_n=0 at shift 7 of a 4321 conversion → all outputs return to reset values immediately, and the display stays 0 after release.
